// File: rtl/m10k_matrix_mover.sv
// m10k_matrix_mover: reads R rows from a single-port M10K into a local buffer,
//   then writes them back at a new base as a straight copy or transposed.
// Latency: start accepted at edge 0, writes in cycles 1+R+RD_LAT..2R+RD_LAT,
//   o_done pulses in cycle 2R+RD_LAT+1 (cycle 1 when R==0).
// Backpressure: none. The RAM is assumed to accept one access per cycle, and
//   i_start is ignored while o_busy is high.
// Ports: i_clk/i_rst clock and async reset; i_start/i_mode/i_rd_base/i_wr_base/
//   i_rows are the command; i_read_data is the RAM read data; o_address/o_wr_en/
//   o_write_data drive the RAM; o_busy/o_done/o_state report status.
module m10k_matrix_mover #(
  parameter int DATA_LEN     = 32,
  parameter int M            = 8,
  parameter int N            = 8,
  parameter int ADDRESS_SIZE = 4,
  parameter int RD_LAT       = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [ADDRESS_SIZE-1:0]   i_rd_base,
  input  logic [ADDRESS_SIZE-1:0]   i_wr_base,
  input  logic [$clog2(M+1)-1:0]    i_rows,
  input  logic [DATA_LEN*N-1:0]     i_read_data,
  output logic [ADDRESS_SIZE-1:0]   o_address,
  output logic                      o_wr_en,
  output logic [DATA_LEN*N-1:0]     o_write_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [2:0]                o_state
);

  localparam int RW = $clog2(M+1);
  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int W  = DATA_LEN*N;
  localparam bit TRANSPOSE_OK = (M == N);

  localparam logic [2:0] S_IDLE  = 3'd7;
  localparam logic [2:0] S_READ  = 3'd0;
  localparam logic [2:0] S_DRAIN = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;

  logic [2:0]              r_state;
  logic                    r_mode;
  logic [ADDRESS_SIZE-1:0] r_rd_base;
  logic [ADDRESS_SIZE-1:0] r_wr_base;
  logic [RW-1:0]           r_rows;
  logic [RW-1:0]           r_cnt;
  logic [1:0]              r_dcnt;
  logic [RD_LAT-1:0]       r_pv;
  logic [IW-1:0]           r_pidx [RD_LAT];
  logic [W-1:0]            r_buf  [M];

  logic [RW-1:0]           w_rows_eff;
  logic                    w_last;
  logic [IW-1:0]           w_cidx;
  logic [ADDRESS_SIZE-1:0] w_cnt_addr;
  logic [W-1:0]            w_tdat;

  // Transpose always moves a full square, so the requested row count is ignored.
  always_comb begin
    w_rows_eff = i_rows;
    if (TRANSPOSE_OK && i_mode)
      w_rows_eff = RW'(M);
    else if (i_rows > RW'(M))
      w_rows_eff = RW'(M);
  end

  assign w_last     = (RW'(r_cnt + 1'b1) == r_rows);
  assign w_cidx     = IW'(r_cnt);
  assign w_cnt_addr = ADDRESS_SIZE'(r_cnt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_rd_base <= '0;
      r_wr_base <= '0;
      r_rows    <= '0;
      r_cnt     <= '0;
      r_dcnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mode    <= i_mode & TRANSPOSE_OK;
            r_rd_base <= i_rd_base;
            r_wr_base <= i_wr_base;
            r_rows    <= w_rows_eff;
            r_cnt     <= '0;
            r_state   <= (w_rows_eff == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == 2'(RD_LAT-1)) r_state <= S_WRITE;
          else                        r_dcnt  <= r_dcnt + 1'b1;
        end
        S_WRITE: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid/row-index shift chain: the tail lines up with the RAM returning
  // data for the address presented RD_LAT cycles earlier.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pv <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pidx[i] <= '0;
    end else begin
      r_pv[0]   <= (r_state == S_READ);
      r_pidx[0] <= w_cidx;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end

  // Buffer contents need no reset; every row used is written before it is read.
  always_ff @(posedge i_clk) begin
    if (r_pv[RD_LAT-1]) r_buf[r_pidx[RD_LAT-1]] <= i_read_data;
  end

  generate
    if (TRANSPOSE_OK) begin : g_tp
      for (genvar j = 0; j < N; j++) begin : g_word
        assign w_tdat[DATA_LEN*j +: DATA_LEN] = r_buf[j][DATA_LEN*w_cidx +: DATA_LEN];
      end
    end else begin : g_no_tp
      assign w_tdat = '0;
    end
  endgenerate

  always_comb begin
    o_address    = '0;
    o_wr_en      = 1'b0;
    o_write_data = '0;
    case (r_state)
      S_READ: o_address = r_rd_base + w_cnt_addr;
      S_WRITE: begin
        o_wr_en      = 1'b1;
        o_address    = r_wr_base + w_cnt_addr;
        o_write_data = r_mode ? w_tdat : r_buf[w_cidx];
      end
      default: ;
    endcase
  end

  assign o_state = r_state;
  assign o_busy  = (r_state != S_IDLE);
  assign o_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_m10k_matrix_mover.sv
// tb_m10k_matrix_mover: drives two movers (RD_LAT=1 and RD_LAT=2), each with
//   its own behavioural 16-row RAM, and checks every write against a queue of
//   expected address/data pairs built when the command is issued.
module tb_m10k_matrix_mover;

  logic              clk;
  logic              rst;
  logic [1:0]        start;
  logic [1:0]        mode;
  logic [1:0][3:0]   rd_base;
  logic [1:0][3:0]   wr_base;
  logic [1:0][3:0]   rows_i;
  logic [1:0][255:0] rdata;
  logic [1:0][3:0]   addr;
  logic [1:0]        wr_en;
  logic [1:0][255:0] wdata;
  logic [1:0]        busy;
  logic [1:0]        done;
  logic [1:0][2:0]   state;
  logic [1:0]        init_req;

  logic [255:0] mem [2][16];
  logic [255:0] rp0 [2];
  logic [255:0] rp1;

  typedef struct {
    logic [3:0]   a;
    logic [255:0] d;
  } wr_t;
  wr_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  m10k_matrix_mover #(.RD_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_mode(mode[0]),
    .i_rd_base(rd_base[0]), .i_wr_base(wr_base[0]), .i_rows(rows_i[0]),
    .i_read_data(rdata[0]), .o_address(addr[0]), .o_wr_en(wr_en[0]),
    .o_write_data(wdata[0]), .o_busy(busy[0]), .o_done(done[0]), .o_state(state[0])
  );

  m10k_matrix_mover #(.RD_LAT(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_mode(mode[1]),
    .i_rd_base(rd_base[1]), .i_wr_base(wr_base[1]), .i_rows(rows_i[1]),
    .i_read_data(rdata[1]), .o_address(addr[1]), .o_wr_en(wr_en[1]),
    .o_write_data(wdata[1]), .o_busy(busy[1]), .o_done(done[1]), .o_state(state[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word j of row r holds 16*r+j.
  function automatic logic [255:0] pat(input int r);
    logic [255:0] p;
    for (int j = 0; j < 8; j++) p[32*j +: 32] = 32'(16*r + j);
    return p;
  endfunction

  // RAM models: synchronous read of 1 or 2 cycles, write on enable.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (init_req[g]) begin
        for (int r = 0; r < 16; r++) mem[g][r] <= pat(r);
      end else if (wr_en[g]) begin
        mem[g][addr[g]] <= wdata[g];
      end
      rp0[g] <= mem[g][addr[g]];
    end
    rp1 <= rp0[1];
  end
  assign rdata[0] = rp0[0];
  assign rdata[1] = rp1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic ram_init(input int g);
    @(negedge clk); init_req[g] = 1'b1;
    @(negedge clk); init_req[g] = 1'b0;
  endtask

  // Build the expected write stream from the pattern-filled RAM.
  task automatic sb_push(input int g, input logic md, input int rd, input int wr, input int cnt);
    wr_t e;
    logic [255:0] src;
    for (int k = 0; k < cnt; k++) begin
      e.a = 4'((wr + k) % 16);
      if (md) begin
        for (int j = 0; j < 8; j++) begin
          src = pat((rd + j) % 16);
          e.d[32*j +: 32] = src[32*k +: 32];
        end
      end else begin
        e.d = pat((rd + k) % 16);
      end
      sb.push_back(e);
    end
  endtask

  task automatic sb_pop(input int g);
    wr_t e;
    if (sb.size() == 0) begin
      chk("unexpected_write", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("wr_addr", addr[g], e.a);
      chk("wr_data", wdata[g], e.d);
    end
  endtask

  task automatic run_op(input int g, input logic md, input int rd, input int wr,
                        input int rws, input bit poke);
    int eff, exp_done, nwr, done_cyc, idle_bad;
    bit addr_moved;
    eff = md ? 8 : ((rws > 8) ? 8 : rws);
    exp_done = (eff == 0) ? 1 : 2*eff + (g+1) + 1;
    nwr = 0; done_cyc = 0; idle_bad = 0; addr_moved = 0;
    sb_push(g, md, rd, wr, eff);
    @(negedge clk);
    start[g] = 1'b1; mode[g] = md;
    rd_base[g] = 4'(rd); wr_base[g] = 4'(wr); rows_i[g] = 4'(rws);
    @(negedge clk);
    // Scramble the command inputs to prove they were latched.
    start[g] = 1'b0; mode[g] = ~md; rd_base[g] = 4'(rd + 5); wr_base[g] = 4'(wr + 3); rows_i[g] = 4'd1;
    chk("busy_cycle1", busy[g], 1);
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) @(negedge clk);
      if (poke && n == 2) start[g] = 1'b1;
      if (poke && n == 3) start[g] = 1'b0;
      if (addr[g] != 4'd0) addr_moved = 1'b1;
      if (wr_en[g]) begin
        nwr++;
        sb_pop(g);
      end
      if (done[g]) begin
        done_cyc = n;
        if (poke) start[g] = 1'b1;
        break;
      end
    end
    chk("done_cycle", done_cyc, exp_done);
    chk("write_count", nwr, eff);
    chk("sb_empty", sb.size(), 0);
    if (eff == 0) chk("no_addr_change", addr_moved, 0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      start[g] = 1'b0;
      if (busy[g] || wr_en[g]) idle_bad++;
    end
    chk("idle_after_op", idle_bad, 0);
    sb.delete();
  endtask

  initial begin
    int nwr;
    rst = 1'b1; start = '0; mode = '0; rd_base = '0; wr_base = '0; rows_i = '0;
    init_req = '0;
    #3;
    for (int g = 0; g < 2; g++) begin
      chk("rst_state", state[g], 3'd7);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_wr_en", wr_en[g], 0);
      chk("rst_addr", addr[g], 0);
      chk("rst_wdata", wdata[g], 0);
    end
    @(negedge clk); rst = 1'b0;
    ram_init(0); ram_init(1);

    // Copy 8 rows, 0..7 -> 8..15, RD_LAT=1.
    run_op(0, 1'b0, 0, 8, 8, 1'b0);
    chk("copy_mem_row12", mem[0][12], pat(4));

    // Transpose with RD_LAT=2; row count is ignored.
    run_op(1, 1'b1, 0, 8, 3, 1'b0);
    begin
      logic [255:0] row;
      row = mem[1][10];
      chk("tp_row2_word5", row[32*5 +: 32], 32'd82);
    end

    // Address wrap with overlapping ranges.
    ram_init(0);
    run_op(0, 1'b0, 14, 15, 4, 1'b0);
    chk("wrap_mem_row2", mem[0][2], pat(1));
    chk("wrap_mem_row0", mem[0][0], pat(15));

    // Zero rows and over-range row count.
    ram_init(0);
    run_op(0, 1'b0, 3, 9, 0, 1'b0);
    run_op(0, 1'b0, 0, 8, 12, 1'b0);
    run_op(1, 1'b0, 5, 0, 2, 1'b0);

    // i_start pulses during READ and DONE must be ignored.
    ram_init(0);
    run_op(0, 1'b0, 2, 10, 5, 1'b1);

    // Reset during the third write cycle.
    ram_init(0);
    nwr = 0;
    sb_push(0, 1'b0, 0, 8, 2);
    @(negedge clk);
    start[0] = 1'b1; mode[0] = 1'b0; rd_base[0] = 4'd0; wr_base[0] = 4'd8; rows_i[0] = 4'd8;
    @(negedge clk);
    start[0] = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      if (n > 1) @(negedge clk);
      if (wr_en[0]) begin
        nwr++;
        sb_pop(0);
      end
    end
    @(negedge clk);
    chk("rst_test_nwr", nwr, 2);
    chk("wr_en_before_rst", wr_en[0], 1);
    rst = 1'b1;
    #1;
    chk("abort_wr_en", wr_en[0], 0);
    chk("abort_state", state[0], 3'd7);
    chk("abort_busy", busy[0], 0);
    @(negedge clk); rst = 1'b0;
    sb.delete();
    chk("abort_row8", mem[0][8], pat(0));
    chk("abort_row9", mem[0][9], pat(1));
    chk("abort_row10", mem[0][10], pat(10));

    // Normal operation after the abort.
    ram_init(0);
    run_op(0, 1'b0, 1, 6, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/m10k_matrix_mover.md
Name: m10k_matrix_mover

Overview:
Parametrised successor to the fixed 8x8 M10K read/write engine. It reads a configurable number of rows from an M10K port starting at a runtime base address and buffers them. It then writes the rows back at a runtime destination base, either as a straight copy or transposed. It sits between the matrix datapath controller and a single-port M10K, and supports synchronous RAM read latency of 1 or 2 cycles.

Parameters:
DATA_LEN, 32, bits per matrix element
M, 8, maximum rows buffered (buffer depth)
N, 8, elements per row (row width = DATA_LEN*N)
ADDRESS_SIZE, 4, M10K address width
RD_LAT, 1, M10K read latency in cycles; legal values 1 or 2

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start request, sampled only in IDLE
i_mode  in  1  0 = copy, 1 = transpose (honoured only when M==N; otherwise treated as copy)
i_rd_base  in  ADDRESS_SIZE  source row base address, latched at start
i_wr_base  in  ADDRESS_SIZE  destination row base address, latched at start
i_rows  in  $clog2(M+1)  row count R, latched at start
i_read_data  in  DATA_LEN*N  M10K read data
o_address  out  ADDRESS_SIZE  M10K address
o_wr_en  out  1  M10K write enable
o_write_data  out  DATA_LEN*N  M10K write data
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle completion pulse
o_state  out  3  current state code: IDLE=7, READ=0, DRAIN=1, WRITE=2, DONE=3

Behaviour:
- Reset (i_rst=1, asynchronous) forces:
  - state IDLE
  - o_address=0, o_wr_en=0, o_write_data=0, o_busy=0, o_done=0
  - row counters and the latency pipeline cleared
  - buffer contents undefined
- Reset mid-operation aborts immediately. No further write occurs after reset asserts.
- Start acceptance:
  - In IDLE with i_start=1, latch i_mode, i_rd_base, i_wr_base and i_rows.
  - Effective R = min(i_rows, M).
  - In transpose mode (M==N), R is forced to M and i_rows is ignored.
  - i_start outside IDLE is ignored.
- R==0: IDLE -> DONE on the next edge. No RAM access; o_done pulses for 1 cycle.
- READ state, R cycles, k=0..R-1:
  - o_address = (i_rd_base + k) mod 2^ADDRESS_SIZE, o_wr_en=0.
  - One address per cycle, back to back.
- Capture timing: data for the address presented in cycle c is sampled from i_read_data at the end of cycle c+RD_LAT into buffer row k. A valid/index shift pipeline of depth RD_LAT tracks this.
- DRAIN state: exactly RD_LAT cycles, waiting for outstanding reads. o_address=0, o_wr_en=0.
- WRITE state, R cycles, k=0..R-1:
  - o_wr_en=1, o_address = (i_wr_base + k) mod 2^ADDRESS_SIZE.
  - Copy mode: o_write_data = buffer row k.
  - Transpose mode: word j of o_write_data = word k of buffer row j.
  - Word j of a row occupies bits [DATA_LEN*j +: DATA_LEN].
- DONE state: 1 cycle, o_done=1, o_busy=1, then back to IDLE. i_start in DONE is ignored.
- Timing summary (R>0): i_start is accepted at edge 0. Write cycles are 1+R+RD_LAT .. 2R+RD_LAT. o_done is high in cycle 2R+RD_LAT+1.
- Addresses wrap modulo 2^ADDRESS_SIZE and the block does not detect overlap. Overlapping source and destination ranges are safe because all reads complete before any write.
- o_address, o_wr_en and o_write_data are driven combinationally from registered state, counter and buffer only; there is no path from any input to any output.
- o_wr_en is never high outside WRITE.

Test Plan:
- Copy, R=8, rd_base=0, wr_base=8, RD_LAT=1, RAM rows preloaded with word j of row r = 16*r+j -> addresses 8..15 written with identical rows; o_done in cycle 18 after start.
- Transpose, M=N=8, i_rows=3 (ignored), RD_LAT=2 -> 8 reads and 8 writes; row 2 word 5 at destination = 16*5+2 = 82; o_done in cycle 19.
- Wrap: rd_base=14, wr_base=15, R=4, copy -> reads 14,15,0,1; writes 15,0,1,2 with source data preserved because of read-before-write.
- i_rows=0 -> no o_wr_en and no address change; o_done high in cycle 1. i_rows=12 with M=8 -> clamped to 8 writes.
- i_start pulsed during READ and DONE -> ignored; exactly one operation completes.
- i_rst asserted during the 3rd WRITE cycle -> o_wr_en=0 immediately (asynchronous), state IDLE, o_busy=0. Only 2 rows are modified, and a new start afterwards works normally.
